stream_downsizer: RTL

Reader-side counterpart to the valid/grant FIFO: drains wide words from a FIFO pop port and emits them as a sequence of narrow beats on a downstream valid/grant port. It sits between a DATA_WIDTH FIFO and a narrower consumer, for example a link or serial interface. It holds one word in a register and sustains one output beat per cycle with no bubble between words.

---
 rtl/stream_pkg.sv | 16 +
 rtl/stream_downsizer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream width converters.
//   stream_dsz_state_e : downsizer FSM state (IDLE waits for a word, SHIFT emits beats)
//   beat_idx_w()       : width of a beat index for a given beats-per-word ratio
package stream_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } stream_dsz_state_e;

  // Never returns zero, so a beat index is always at least one bit wide.
  function automatic int unsigned beat_idx_w(input int unsigned ratio);
    return (ratio <= 1) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/stream_downsizer.sv
// Wide-to-narrow stream converter. Pops one IN_WIDTH word from a FIFO and emits it as
// RATIO = IN_WIDTH/OUT_WIDTH narrow beats, one per cycle, with no bubble between words.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active-high
//   data_i   in   [IN_WIDTH]  word from the FIFO pop side
//   valid_i  in   word available
//   grant_o  out  word accepted this cycle (pops the FIFO)
//   data_o   out  [OUT_WIDTH] current beat
//   valid_o  out  beat valid
//   last_o   out  current beat is the final slice of its word
//   grant_i  in   downstream accepts the beat
module stream_downsizer
  import stream_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  data_i,
  input  logic                 valid_i,
  output logic                 grant_o,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 valid_o,
  output logic                 last_o,
  input  logic                 grant_i
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned CNT_W = beat_idx_w(RATIO);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

  generate
    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_param_err
      $error("stream_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
    end
  endgenerate

  stream_dsz_state_e state_q, state_d;
  logic [IN_WIDTH-1:0] word_q;
  logic [CNT_W-1:0]    cnt_q;

  logic word_load;  // capture data_i and restart at beat 0
  logic cnt_inc;    // advance to the next beat
  logic cnt_clr;    // return the counter to 0 on the final beat
  logic is_last;

  // View the held word as an array of beats; index 0 is the least-significant slice.
  logic [RATIO-1:0][OUT_WIDTH-1:0] word_beats;
  logic [CNT_W-1:0]                beat_sel;

  assign word_beats = word_q;
  assign is_last    = (cnt_q == LAST_IDX);
  assign beat_sel   = LSB_FIRST ? cnt_q : (LAST_IDX - cnt_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    word_load = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          word_load = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (grant_i) begin
          if (!is_last) begin
            cnt_inc = 1'b1;
          end else begin
            cnt_clr = 1'b1;
            if (valid_i) begin
              // Back-to-back: the next word follows the last beat with no idle cycle.
              word_load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word and beat counter. The counter is cleared explicitly on the last beat, so it
  // never leaves 0..RATIO-1 even when RATIO is not a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (word_load) begin
        word_q <= data_i;
      end
      if (word_load || cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Outputs. Everything is forced low while rst is held, including the IDLE grant.
  // grant_o depends combinationally on grant_i in SHIFT so a new word can be popped in
  // the same cycle the last beat leaves.
  always_comb begin
    valid_o = 1'b0;
    last_o  = 1'b0;
    data_o  = '0;
    grant_o = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          grant_o = 1'b1;
        end
        SHIFT: begin
          valid_o = 1'b1;
          last_o  = is_last;
          data_o  = word_beats[beat_sel];
          grant_o = is_last && grant_i;
        end
        default: ;
      endcase
    end
  end

endmodule
